switch_core: RTL
================

# switch_core

Central arbiter and crossbar of the packet switch. It sits between the N_DEV bidirectional ports. Each cycle it collects the ports' transmit requests and picks one winner by round-robin, with destination-full re-checking. It returns a one-cycle grant to the winner and writes the winner's data word into the destination port's receive FIFO through a one-cycle write strobe. Each port's RX side then drains its FIFO toward its device independently.

## Interface
- AW_DEV, 2, address width of a target device
- DW, 4, data word width
- N_DEV, 1<<AW_DEV, number of ports (one requester and one destination per port)

- clk_i  in  1  switch clock, all state on rising edge
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- rqt_i  in  N_DEV  request from port k (combinational in the port, drops the cycle after its grant)
- dat_i  in  N_DEV*DW  device TX data; port k occupies bits [k*DW +: DW]
- adr_i  in  N_DEV*AW_DEV  device TX destination; port k occupies bits [k*AW_DEV +: AW_DEV]
- full_i  in  N_DEV  receive-FIFO full flag of each port
- gnt_o  out  N_DEV  one-hot grant pulse to the winning port
- wen_o  out  N_DEV  one-hot write strobe to the destination port FIFO
- fifo_o  out  DW  data word broadcast to all port FIFO inputs
- busy_o  out  1  high while in GRANT state

## Operation
- State: 2-state FSM {ARB, GRANT}, round-robin pointer ptr (AW_DEV bits), last winner lw (AW_DEV bits), registered output strobes.
- Eligibility of port k in the decision cycle:
  - rqt_i[k] is high;
  - full_i[adr_k] is low;
  - and, when the FSM is in GRANT, k is not lw. This masks the port whose rqt has not yet dropped.
- Selection: the first eligible k searched ptr, ptr+1, …, ptr+N_DEV-1, with wrap-around mod N_DEV.
- ARB with a winner w:
  - Next cycle the FSM is in GRANT.
  - gnt_o = 1<<w.
  - wen_o = 1<<adr_w, where adr_w is sampled this cycle.
  - fifo_o = dat_w, sampled this cycle.
  - lw = w and ptr = w+1 mod N_DEV.
- ARB with no winner: stay in ARB with all strobes low.
- GRANT: strobes are high for this cycle only. Arbitration runs again in this cycle with lw masked.
  - Winner found: back-to-back GRANT, with the same update rules as ARB.
  - No winner: return to ARB.
- Loopback (adr_w == w) is legal.
- A simultaneous request from every port is served in round-robin order, and no port waits more than N_DEV grants.
- full_i rising in the same cycle as the decision suppresses eligibility for that cycle only.
- fifo_o holds its last value when idle. Its content is "don't care" when wen_o is all zero.
- Reset (asynchronous, any state, including mid-GRANT):
  - FSM returns to ARB.
  - ptr = 0 and lw = 0.
  - gnt_o = 0, wen_o = 0, fifo_o = 0, busy_o = 0 immediately.

## Timing
- Decision is combinational from the inputs in cycle c. gnt_o, wen_o and fifo_o are registered and valid for cycle c+1 only, for exactly one cycle.
- Port acktx rises at c+2 and its rqt drops in c+2. The lw mask covers c+1, where rqt is still high.
- Peak throughput: one transfer per cycle when different ports alternate. A single port gets at most one transfer per 2 cycles.
- Latency from rqt_i rising with no contention to gnt_o: 1 cycle.
- gnt_o and wen_o are always one-hot or zero, and they are never asserted without each other.
- Devices hold dat_i and adr_i stable until acktx, per the 4-phase handshake. The switch samples them only in the decision cycle.

## Test plan
- Reset: assert rst_ni=0 mid-GRANT with gnt_o=4'b0010. Required: gnt_o, wen_o, fifo_o and busy_o go to 0 without a clock edge. After release, the first grant with all requesting goes to port 0.
- Single transfer: port 1 requests with adr=3 and dat=4'hA. Required one cycle later: gnt_o=4'b0010, wen_o=4'b1000, fifo_o=4'hA, all for exactly one cycle, and no second grant to port 1 while its rqt is still high.
- Round-robin: ports 0–3 all request continuously, each with a distinct non-full destination. Required grant order: 0,1,2,3,0, on consecutive cycles.
- Full skip: ports 0 and 2 request, with port 0 targeting 1 and full_i[1]=1. Required: port 2 is granted and port 0 stays ungranted until full_i[1]=0, then is granted next.
- Loopback plus back-to-back: port 2 targets itself while port 3 targets 0. Required: wen_o=4'b0100 then wen_o=4'b0001 in consecutive cycles, with fifo_o carrying each port's data in turn.
- Contention fairness: port 0 requests permanently and port 3 pulses its requests. Required: port 3 is never skipped twice in succession.

Source files
------------

// File: rtl/switch_core.sv
// switch_core: central round-robin arbiter and crossbar of the packet switch.
// Each cycle one eligible requester is selected. One cycle later it receives a grant
// pulse, and its data word is written into the destination port's receive FIFO.
module switch_core #(
    parameter int AW_DEV = 2,
    parameter int DW     = 4,
    parameter int N_DEV  = 1 << AW_DEV
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_DEV-1:0]         rqt_i,
    input  logic [N_DEV*DW-1:0]      dat_i,
    input  logic [N_DEV*AW_DEV-1:0]  adr_i,
    input  logic [N_DEV-1:0]         full_i,
    output logic [N_DEV-1:0]         gnt_o,
    output logic [N_DEV-1:0]         wen_o,
    output logic [DW-1:0]            fifo_o,
    output logic                     busy_o
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [N_DEV-1:0]  ONE_HOT0 = {{(N_DEV-1){1'b0}}, 1'b1};
    localparam logic [AW_DEV-1:0] PTR_ONE  = {{(AW_DEV-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [AW_DEV-1:0]  ptr_q, ptr_d;
    logic [AW_DEV-1:0]  lw_q, lw_d;
    logic [N_DEV-1:0]   gnt_q, gnt_d;
    logic [N_DEV-1:0]   wen_q, wen_d;
    logic [DW-1:0]      fifo_q, fifo_d;
    logic               busy_q, busy_d;

    logic [AW_DEV-1:0]  adr_s [N_DEV];
    logic [DW-1:0]      dat_s [N_DEV];
    logic [N_DEV-1:0]   elig_s;
    logic               in_grant_s;
    logic               win_vld_s;
    logic [AW_DEV-1:0]  win_s;

    assign in_grant_s = (state_q == ST_GRANT);

    // Unpack the flat per-port address and data buses into arrays indexed by port
    always_comb begin
        for (int k = 0; k < N_DEV; k++) begin
            adr_s[k] = adr_i[k*AW_DEV +: AW_DEV];
            dat_s[k] = dat_i[k*DW +: DW];
        end
    end

    // A port competes if it requests and its target has room. The port granted last is
    // excluded while in GRANT, because its request has not dropped yet.
    always_comb begin
        for (int k = 0; k < N_DEV; k++) begin
            elig_s[k] = rqt_i[k] & ~full_i[adr_s[k]]
                      & ~(in_grant_s & (lw_q == AW_DEV'(k)));
        end
    end

    // Round-robin search from ptr. The AW_DEV-bit index wraps modulo N_DEV naturally.
    always_comb begin
        logic [AW_DEV-1:0] idx;
        logic              hit;
        idx       = ptr_q;
        hit       = 1'b0;
        win_vld_s = 1'b0;
        win_s     = {AW_DEV{1'b0}};
        for (int i = 0; i < N_DEV; i++) begin
            idx       = ptr_q + AW_DEV'(i);
            hit       = ~win_vld_s & elig_s[idx];
            win_s     = hit ? idx : win_s;
            win_vld_s = win_vld_s | hit;
        end
    end

    // Next state and strobes. ARB and GRANT both arbitrate, and a winner always leads to GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lw_d    = lw_q;
        gnt_d   = {N_DEV{1'b0}};
        wen_d   = {N_DEV{1'b0}};
        fifo_d  = fifo_q;
        busy_d  = 1'b0;
        case (state_q)
            ST_ARB, ST_GRANT: begin
                if (win_vld_s) begin
                    state_d = ST_GRANT;
                    gnt_d   = ONE_HOT0 << win_s;
                    wen_d   = ONE_HOT0 << adr_s[win_s];
                    fifo_d  = dat_s[win_s];
                    lw_d    = win_s;
                    ptr_d   = win_s + PTR_ONE;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State and registered outputs. Asynchronous reset clears every strobe immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ARB;
            ptr_q   <= {AW_DEV{1'b0}};
            lw_q    <= {AW_DEV{1'b0}};
            gnt_q   <= {N_DEV{1'b0}};
            wen_q   <= {N_DEV{1'b0}};
            fifo_q  <= {DW{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lw_q    <= lw_d;
            gnt_q   <= gnt_d;
            wen_q   <= wen_d;
            fifo_q  <= fifo_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign wen_o  = wen_q;
    assign fifo_o = fifo_q;
    assign busy_o = busy_q;

endmodule
